occupancy_tracker: RTL and testbench
====================================

Name: occupancy_tracker

Overview:
Multi-lane parking-lot occupancy counter and the next generation of the single-lane photo-sensor counter. Each lane has an outer/inner photo-sensor pair and its own sequence FSM. An entry or exit is committed only after the full sequence completes and the car has cleared both sensors. A shared saturating occupancy counter, full/empty flags and a sticky overflow/underflow flag feed the HEX display and lot-gate logic.

Parameters:
LANES, 2, number of independent sensor-pair lanes (1..8)
CAPACITY, 16, maximum occupancy (1..255)
CNT_W, $clog2(CAPACITY+1), occupancy counter width (derived, not overridden)

Ports:
Clk  in  1  system clock
Rst  in  1  reset, synchronous, active-high
Sensor  in  2*LANES  lane k uses bits [2k+1:2k]; bit1 = outer beam blocked, bit0 = inner beam blocked; already synchronous to Clk
Enter  out  LANES  one-cycle pulse per lane on a committed entry
Exit  out  LANES  one-cycle pulse per lane on a committed exit
LaneErr  out  LANES  level; lane is in ERR state
Count  out  CNT_W  current occupancy
Full  out  1  Count == CAPACITY
Empty  out  1  Count == 0
Overflow  out  1  sticky; an entry was lost to saturation at CAPACITY, or an exit was lost at 0

Behaviour:
- Reset values: all lane FSMs in IDLE, Count=0, Empty=1, Full=0, Enter=0, Exit=0, LaneErr=0, Overflow=0. Only Rst clears Overflow.
- Rst asserted mid-sequence: every lane returns to IDLE and in-flight sequences are discarded. No pulse is emitted in the reset cycle.
- Per-lane FSM states: IDLE, ENT_O, ENT_B, ENT_I, EXT_I, EXT_B, EXT_O, ERR. Sensor value written as {outer,inner}.
- IDLE: 10 -> ENT_O; 01 -> EXT_I; 11 -> ERR; 00 -> stay.
- ENT_O: 11 -> ENT_B; 00 -> IDLE (abort, no event); 01 -> ERR; 10 -> stay.
- ENT_B: 01 -> ENT_I; 10 -> ENT_O (backing out); 00 -> ERR; 11 -> stay.
- ENT_I: 00 -> IDLE and commit entry; 11 -> ENT_B; 10 -> ERR; 01 -> stay.
- Exit path is the mirror: EXT_I --11--> EXT_B --10--> EXT_O --00--> IDLE and commit exit.
  - EXT_I: 00 -> IDLE (abort, no event).
  - EXT_B: 01 -> EXT_I; 00 -> ERR.
  - EXT_O: 11 -> EXT_B; 01 -> ERR.
  - Any illegal jump -> ERR.
- ERR: stays until the sensor reads 00, then -> IDLE. No event is emitted.
- Commit timing: the clock edge that samples 00 in ENT_I (EXT_O) asserts Enter[k] (Exit[k]) for exactly one cycle. Count updates on the same edge. Latency is one cycle from the 00 input to the visible pulse and count.
- Arbitration: in one cycle, E = number of lanes committing entry and X = number committing exit.
  - Next Count = clamp(Count + E - X, 0, CAPACITY), computed at CNT_W+4 bits signed.
  - Simultaneous entries and exits net out before clamping.
- Saturation: if Count + E - X is above CAPACITY or below 0, Count clamps and Overflow is set. The per-lane Enter/Exit pulses are still emitted, because pulses report physical events.
- Full and Empty are combinational from the registered Count.

Decomposition:
- Package occupancy_pkg holds the lane_state_t enum (8 states above) and the sensor encoding constants S_CLEAR=2'b00, S_INNER=2'b01, S_OUTER=2'b10, S_BOTH=2'b11.
- Sub-module lane_fsm (Clk, Rst, Sensor[1:0] -> enter, exit, err) is instantiated LANES times by a generate loop.
- The top level holds the popcount adders, clamp logic and counter.

Test Plan:
- Reset, then lane0 driven 10,11,01,00 (one cycle each) -> Enter[0] pulses the cycle after 00; Count 0->1; Empty 1->0.
- Lane0 driven 10,11,10,00 (backs out) -> no Enter; Count unchanged; LaneErr[0]=0.
- Lane0 driven 11 from IDLE -> LaneErr[0]=1 until 00 is applied; no Count change.
- Count=5; lane0 completes an entry and lane1 completes an exit on the same edge -> Enter[0] and Exit[1] both pulse; Count stays 5.
- CAPACITY=16: drive 16 entries -> Count=16, Full=1; a 17th entry -> Enter pulses, Count=16, Overflow=1 and stays set; an exit from Count=0 after Rst likewise sets Overflow.
- Assert Rst while lane1 is in ENT_B, then release and apply 01,00 -> lane1 is in IDLE, then goes 01 -> EXT_I, 00 -> IDLE; no Enter; Count=0.

Source files
------------

// File: rtl/occupancy_pkg.sv
// Shared types and sensor encodings for the parking-lot occupancy tracker.
package occupancy_pkg;

   // Per-lane sequence states; sensor pairs are written as {outer,inner}.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENT_O = 3'd1,
      ENT_B = 3'd2,
      ENT_I = 3'd3,
      EXT_I = 3'd4,
      EXT_B = 3'd5,
      EXT_O = 3'd6,
      ERR   = 3'd7
   } lane_state_t;

   localparam logic [1:0] S_CLEAR = 2'b00;
   localparam logic [1:0] S_INNER = 2'b01;
   localparam logic [1:0] S_OUTER = 2'b10;
   localparam logic [1:0] S_BOTH  = 2'b11;

endpackage : occupancy_pkg

// File: rtl/occupancy_tracker_lane_fsm.sv
// One lane's outer/inner photo-sensor sequence tracker.
// commit_*_o are combinational and fire on the cycle that samples the final
// 00; enter_o/exit_o are the registered one-cycle pulses that follow.
module lane_fsm
   import occupancy_pkg::*;
(
   input  logic       Clk,
   input  logic       Rst,
   input  logic [1:0] Sensor,
   output logic       commit_ent_o,
   output logic       commit_ext_o,
   output logic       enter_o,
   output logic       exit_o,
   output logic       err_o
);

   lane_state_t state_q, state_d;
   logic        enter_q, exit_q;

   // Next-state decode and commit detection for the entry/exit sequences.
   always_comb begin
      state_d      = state_q;
      commit_ent_o = 1'b0;
      commit_ext_o = 1'b0;
      case (state_q)
         IDLE: begin
            case (Sensor)
               S_OUTER: state_d = ENT_O;
               S_INNER: state_d = EXT_I;
               S_BOTH:  state_d = ERR;
               default: state_d = IDLE;
            endcase
         end
         ENT_O: begin
            case (Sensor)
               S_BOTH:  state_d = ENT_B;
               S_CLEAR: state_d = IDLE;
               S_INNER: state_d = ERR;
               default: state_d = ENT_O;
            endcase
         end
         ENT_B: begin
            case (Sensor)
               S_INNER: state_d = ENT_I;
               S_OUTER: state_d = ENT_O;
               S_CLEAR: state_d = ERR;
               default: state_d = ENT_B;
            endcase
         end
         ENT_I: begin
            case (Sensor)
               S_CLEAR: begin
                  state_d      = IDLE;
                  commit_ent_o = 1'b1;
               end
               S_BOTH:  state_d = ENT_B;
               S_OUTER: state_d = ERR;
               default: state_d = ENT_I;
            endcase
         end
         EXT_I: begin
            case (Sensor)
               S_BOTH:  state_d = EXT_B;
               S_CLEAR: state_d = IDLE;
               S_OUTER: state_d = ERR;
               default: state_d = EXT_I;
            endcase
         end
         EXT_B: begin
            case (Sensor)
               S_OUTER: state_d = EXT_O;
               S_INNER: state_d = EXT_I;
               S_CLEAR: state_d = ERR;
               default: state_d = EXT_B;
            endcase
         end
         EXT_O: begin
            case (Sensor)
               S_CLEAR: begin
                  state_d      = IDLE;
                  commit_ext_o = 1'b1;
               end
               S_BOTH:  state_d = EXT_B;
               S_INNER: state_d = ERR;
               default: state_d = EXT_O;
            endcase
         end
         default: begin
            if (Sensor == S_CLEAR) state_d = IDLE;
         end
      endcase
   end

   // State register and registered event pulses; reset discards in-flight sequences.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         enter_q <= 1'b0;
         exit_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         enter_q <= commit_ent_o;
         exit_q  <= commit_ext_o;
      end
   end

   assign enter_o = enter_q;
   assign exit_o  = exit_q;
   assign err_o   = (state_q == ERR);

endmodule : lane_fsm

// File: rtl/occupancy_tracker.sv
// Multi-lane occupancy counter: per-lane sequence FSMs feed a shared
// saturating counter with full/empty flags and a sticky overflow flag.
module occupancy_tracker
   import occupancy_pkg::*;
#(
   parameter  int unsigned LANES    = 2,
   parameter  int unsigned CAPACITY = 16,
   localparam int unsigned CNT_W    = $clog2(CAPACITY + 1)
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [2*LANES-1:0]   Sensor,
   output logic [LANES-1:0]     Enter,
   output logic [LANES-1:0]     Exit,
   output logic [LANES-1:0]     LaneErr,
   output logic [CNT_W-1:0]     Count,
   output logic                 Full,
   output logic                 Empty,
   output logic                 Overflow
);

   localparam int unsigned SUM_W = CNT_W + 4;
   localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

   logic [LANES-1:0]        ent_commit, ext_commit;
   logic [SUM_W-1:0]        ent_cnt, ext_cnt;
   logic signed [SUM_W-1:0] sum;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    ovf_q, ovf_d;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_fsm u_lane (
         .Clk          (Clk),
         .Rst          (Rst),
         .Sensor       (Sensor[2*g+1:2*g]),
         .commit_ent_o (ent_commit[g]),
         .commit_ext_o (ext_commit[g]),
         .enter_o      (Enter[g]),
         .exit_o       (Exit[g]),
         .err_o        (LaneErr[g])
      );
   end

   // Popcount of lanes committing this cycle, then net and clamp.
   always_comb begin
      ent_cnt = '0;
      ext_cnt = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         ent_cnt = ent_cnt + SUM_W'(ent_commit[i]);
         ext_cnt = ext_cnt + SUM_W'(ext_commit[i]);
      end
      sum     = $signed({4'b0000, count_q}) + $signed(ent_cnt) - $signed(ext_cnt);
      count_d = sum[CNT_W-1:0];
      ovf_d   = ovf_q;
      if (sum < 0) begin
         count_d = '0;
         ovf_d   = 1'b1;
      end else if (sum > CAP_S) begin
         count_d = CNT_W'(CAPACITY);
         ovf_d   = 1'b1;
      end
   end

   // Occupancy counter and sticky overflow flag.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign Count    = count_q;
   assign Overflow = ovf_q;
   assign Full     = (count_q == CNT_W'(CAPACITY));
   assign Empty    = (count_q == '0);

endmodule : occupancy_tracker

// File: tb/tb_occupancy_tracker.sv
// Directed bench for occupancy_tracker (LANES=2, CAPACITY=16) with a
// one-cycle-latency expectation queue.
module tb_occupancy_tracker;

   localparam int CAP = 16;

   logic       Clk = 1'b0;
   logic       Rst;
   logic [3:0] Sensor;
   logic [1:0] Enter, Exit, LaneErr;
   logic [4:0] Count;
   logic       Full, Empty, Overflow;

   typedef struct {
      logic [1:0] en;
      logic [1:0] ex;
      logic [1:0] er;
      logic [4:0] cnt;
      logic       full;
      logic       empty;
      logic       ovf;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   exp_cnt = 0;
   logic exp_ovf = 1'b0;

   occupancy_tracker #(.LANES(2), .CAPACITY(CAP)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Sensor   (Sensor),
      .Enter    (Enter),
      .Exit     (Exit),
      .LaneErr  (LaneErr),
      .Count    (Count),
      .Full     (Full),
      .Empty    (Empty),
      .Overflow (Overflow)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [1:0] en, input logic [1:0] ex, input logic [1:0] er);
      exp_t e;
      e.en    = en;
      e.ex    = ex;
      e.er    = er;
      e.cnt   = 5'(exp_cnt);
      e.full  = (exp_cnt == CAP);
      e.empty = (exp_cnt == 0);
      e.ovf   = exp_ovf;
      sb.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".enter"}, 8'(Enter),    8'(e.en));
         chk({tag, ".exit"},  8'(Exit),     8'(e.ex));
         chk({tag, ".err"},   8'(LaneErr),  8'(e.er));
         chk({tag, ".count"}, 8'(Count),    8'(e.cnt));
         chk({tag, ".full"},  8'(Full),     8'(e.full));
         chk({tag, ".empty"}, 8'(Empty),    8'(e.empty));
         chk({tag, ".ovf"},   8'(Overflow), 8'(e.ovf));
      end
   endtask

   // Drive one cycle of sensor input with the outputs expected after the edge.
   task automatic step(input string tag, input logic [3:0] s,
                       input logic [1:0] en, input logic [1:0] ex, input logic [1:0] er);
      int n;
      Rst    = 1'b0;
      Sensor = s;
      n = exp_cnt + int'(en[0]) + int'(en[1]) - int'(ex[0]) - int'(ex[1]);
      if (n > CAP) begin
         n = CAP;
         exp_ovf = 1'b1;
      end else if (n < 0) begin
         n = 0;
         exp_ovf = 1'b1;
      end
      exp_cnt = n;
      push(en, ex, er);
      @(posedge Clk);
      #1;
      pop_check(tag);
   endtask

   task automatic do_reset(input string tag, input logic [3:0] s);
      Rst     = 1'b1;
      Sensor  = s;
      exp_cnt = 0;
      exp_ovf = 1'b0;
      push(2'b00, 2'b00, 2'b00);
      @(posedge Clk);
      #1;
      pop_check(tag);
   endtask

   task automatic entry0(input string tag);
      step({tag, ".o"}, 4'b0010, 2'b00, 2'b00, 2'b00);
      step({tag, ".b"}, 4'b0011, 2'b00, 2'b00, 2'b00);
      step({tag, ".i"}, 4'b0001, 2'b00, 2'b00, 2'b00);
      step({tag, ".c"}, 4'b0000, 2'b01, 2'b00, 2'b00);
   endtask

   initial begin
      Rst    = 1'b1;
      Sensor = 4'b0000;
      @(posedge Clk);
      do_reset("reset", 4'b0000);

      // Basic entry on lane0
      entry0("entry1");
      step("after_entry", 4'b0000, 2'b00, 2'b00, 2'b00);

      // Back out of an entry: no event
      step("bo.o",  4'b0010, 2'b00, 2'b00, 2'b00);
      step("bo.b",  4'b0011, 2'b00, 2'b00, 2'b00);
      step("bo.o2", 4'b0010, 2'b00, 2'b00, 2'b00);
      step("bo.c",  4'b0000, 2'b00, 2'b00, 2'b00);

      // Both beams from IDLE is an error until clear
      step("err.a", 4'b0011, 2'b00, 2'b00, 2'b01);
      step("err.b", 4'b0011, 2'b00, 2'b00, 2'b01);
      step("err.c", 4'b0000, 2'b00, 2'b00, 2'b00);

      // Bring Count to 5
      for (int i = 0; i < 4; i++) entry0("fill5");

      // Simultaneous entry on lane0 and exit on lane1 net out
      step("sim.1", 4'b0110, 2'b00, 2'b00, 2'b00);
      step("sim.2", 4'b1111, 2'b00, 2'b00, 2'b00);
      step("sim.3", 4'b1001, 2'b00, 2'b00, 2'b00);
      step("sim.c", 4'b0000, 2'b01, 2'b10, 2'b00);

      // Fill to capacity
      for (int i = 0; i < 11; i++) entry0("fill16");
      // 17th entry saturates
      entry0("sat17");
      // Both lanes entering at full also saturate
      step("dbl.1", 4'b1010, 2'b00, 2'b00, 2'b00);
      step("dbl.2", 4'b1111, 2'b00, 2'b00, 2'b00);
      step("dbl.3", 4'b0101, 2'b00, 2'b00, 2'b00);
      step("dbl.c", 4'b0000, 2'b11, 2'b00, 2'b00);
      // Overflow is sticky across a normal exit on lane1
      step("ex1.i", 4'b0100, 2'b00, 2'b00, 2'b00);
      step("ex1.b", 4'b1100, 2'b00, 2'b00, 2'b00);
      step("ex1.o", 4'b1000, 2'b00, 2'b00, 2'b00);
      step("ex1.c", 4'b0000, 2'b00, 2'b10, 2'b00);

      // Reset clears Overflow; exit from empty sets it again
      do_reset("reset2", 4'b0000);
      step("under.i", 4'b0001, 2'b00, 2'b00, 2'b00);
      step("under.b", 4'b0011, 2'b00, 2'b00, 2'b00);
      step("under.o", 4'b0010, 2'b00, 2'b00, 2'b00);
      step("under.c", 4'b0000, 2'b00, 2'b01, 2'b00);

      // Reset while lane1 is in ENT_B discards the sequence
      do_reset("reset3", 4'b0000);
      step("mid.o", 4'b1000, 2'b00, 2'b00, 2'b00);
      step("mid.b", 4'b1100, 2'b00, 2'b00, 2'b00);
      do_reset("mid.rst", 4'b1100);
      step("mid.i", 4'b0100, 2'b00, 2'b00, 2'b00);
      step("mid.c", 4'b0000, 2'b00, 2'b00, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_occupancy_tracker
